store_retire_ctrl: RTL and testbench

Sequences retirement of committed stores from the store queue head into the data cache. Sits between ROB retire, SQ head, and dcache write port. It captures the SQ head when the ROB retires a store and issues it to the dcache with a valid/ready handshake. It tracks outstanding writes and drives `dcache_store_stall` back to the ROB so no further store retires while the controller cannot accept one.

---
 rtl/store_retire_ctrl_pkg.sv | 25 ++
 rtl/store_retire_ctrl_updown_counter.sv | 40 ++++
 rtl/store_retire_ctrl.sv | 94 +++++++++
 tb/tb_store_retire_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_retire_ctrl_pkg.sv
// Shared types for the store retirement path: request payload, access size
// and the retire controller state encoding.
package store_retire_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } MEM_SIZE;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    MEM_SIZE         size;
  } STORE_REQ;

  typedef enum logic {
    SRC_IDLE = 1'b0,
    SRC_HOLD = 1'b1
  } SRC_STATE;

endpackage

// File: rtl/store_retire_ctrl_updown_counter.sv
// Saturating up/down counter with at-max / at-zero flags; simultaneous
// increment and decrement cancel out.
module updown_counter #(
  parameter int MAX_VAL = 2,
  parameter int W       = $clog2(MAX_VAL + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         at_max_o,
  output logic         at_zero_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX_VAL);

  logic [W-1:0] count_q, count_d;

  assign count_o   = count_q;
  assign at_max_o  = (count_q == MAX_C);
  assign at_zero_o = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !at_max_o) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && !at_zero_o) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/store_retire_ctrl.sv
// Retires committed stores from the SQ head into the dcache: one holding
// register, valid/ready issue, and an outstanding-write limit fed back to the ROB.
module store_retire_ctrl
  import store_retire_ctrl_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rob2sq_retire_en,
  input  logic             sq_head_valid,
  input  STORE_REQ         sq_head,
  output logic             sq_retire,
  output logic             dc_req_valid,
  output STORE_REQ         dc_req,
  input  logic             dc_req_ready,
  input  logic             dc_resp_valid,
  output logic             dcache_store_stall,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             drained,
  output logic             err
);

  SRC_STATE state_q, state_d;
  STORE_REQ hold_q, hold_d;
  logic     err_q, err_d;
  logic     accept, issue, cnt_at_max, cnt_at_zero;

  updown_counter #(
    .MAX_VAL (MAX_OUTSTANDING),
    .W       (CNT_W)
  ) u_outstanding (
    .clk       (clock),
    .rst_n     (reset_n),
    .inc_i     (issue),
    .dec_i     (dc_resp_valid),
    .count_o   (outstanding_cnt),
    .at_max_o  (cnt_at_max),
    .at_zero_o (cnt_at_zero)
  );

  // Stall comes from registers only, so the ROB never sees a path from the dcache handshake.
  assign dcache_store_stall = (state_q == SRC_HOLD) | cnt_at_max;
  assign accept             = rob2sq_retire_en & ~dcache_store_stall;
  assign dc_req_valid       = (state_q == SRC_HOLD);
  assign dc_req             = hold_q;
  assign issue              = dc_req_valid & dc_req_ready;
  assign drained            = (state_q == SRC_IDLE) & cnt_at_zero;
  assign err                = err_q;

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sq_retire = 1'b0;
    err_d     = err_q;

    case (state_q)
      SRC_IDLE: begin
        if (accept && sq_head_valid) begin
          hold_d    = sq_head;
          sq_retire = 1'b1;
          state_d   = SRC_HOLD;
        end
      end
      SRC_HOLD: begin
        if (issue) state_d = SRC_IDLE;
      end
      default: state_d = SRC_IDLE;
    endcase

    // A response that coincides with an issue is legal even at zero.
    if ((accept && !sq_head_valid) || (dc_resp_valid && cnt_at_zero && !issue)) begin
      err_d = 1'b1;
    end
  end

  // NOTE: the holding register is reset too, so the payload reads as zero
  // after reset instead of carrying stale data from a discarded request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SRC_IDLE;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_store_retire_ctrl.sv
// Directed bench for store_retire_ctrl: a scoreboard queue of captured SQ
// heads is matched against every accepted dcache request.
module tb_store_retire_ctrl;
  import store_retire_ctrl_pkg::*;

  localparam int MAX_OUTSTANDING = 2;
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1);

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             rob2sq_retire_en = 1'b0;
  logic             sq_head_valid = 1'b0;
  STORE_REQ         sq_head = '0;
  logic             sq_retire;
  logic             dc_req_valid;
  STORE_REQ         dc_req;
  logic             dc_req_ready = 1'b0;
  logic             dc_resp_valid = 1'b0;
  logic             dcache_store_stall;
  logic [CNT_W-1:0] outstanding_cnt;
  logic             drained;
  logic             err;

  int       vectors     = 0;
  int       miscompares = 0;
  STORE_REQ exp_q[$];

  store_retire_ctrl #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .rob2sq_retire_en   (rob2sq_retire_en),
    .sq_head_valid      (sq_head_valid),
    .sq_head            (sq_head),
    .sq_retire          (sq_retire),
    .dc_req_valid       (dc_req_valid),
    .dc_req             (dc_req),
    .dc_req_ready       (dc_req_ready),
    .dc_resp_valid      (dc_resp_valid),
    .dcache_store_stall (dcache_store_stall),
    .outstanding_cnt    (outstanding_cnt),
    .drained            (drained),
    .err                (err)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  function automatic STORE_REQ mk(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                                  input MEM_SIZE s);
    STORE_REQ r;
    r.addr = a;
    r.data = d;
    r.size = s;
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle, score any request accepted this cycle, then advance to just past the edge.
  task automatic cycle();
    #2;
    if (dc_req_valid && dc_req_ready) begin
      check("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) check("dc_req_payload", dc_req, exp_q.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic retire(input STORE_REQ h, input logic expect_accept);
    rob2sq_retire_en = 1'b1;
    sq_head_valid    = 1'b1;
    sq_head          = h;
    #1;
    check("sq_retire", sq_retire, expect_accept);
    if (expect_accept) exp_q.push_back(h);
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #10;
    check("rst_valid",   dc_req_valid, 1'b0);
    check("rst_retire",  sq_retire, 1'b0);
    check("rst_stall",   dcache_store_stall, 1'b0);
    check("rst_drained", drained, 1'b1);
    check("rst_cnt",     outstanding_cnt, 0);
    check("rst_err",     err, 1'b0);
    check("rst_payload", dc_req, 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single store, ready held high, response four cycles after issue
    dc_req_ready = 1'b1;
    retire(mk(32'h1000, 32'hAB, SIZE_WORD), 1'b1);
    cycle();
    rob2sq_retire_en = 1'b0;
    sq_head_valid    = 1'b0;
    #1;
    check("s1_valid_t1", dc_req_valid, 1'b1);
    check("s1_stall_t1", dcache_store_stall, 1'b1);
    check("s1_addr_t1",  dc_req.addr, 32'h1000);
    cycle();
    check("s1_cnt_t2",     outstanding_cnt, 1);
    check("s1_valid_t2",   dc_req_valid, 1'b0);
    check("s1_stall_t2",   dcache_store_stall, 1'b0);
    check("s1_drained_t2", drained, 1'b0);
    cycle();
    cycle();
    cycle();
    dc_resp_valid = 1'b1;
    cycle();
    dc_resp_valid = 1'b0;
    check("s1_cnt_done",  outstanding_cnt, 0);
    check("s1_drained",   drained, 1'b1);
    check("s1_err",       err, 1'b0);

    // Backpressure: payload held, second retire refused while holding
    dc_req_ready = 1'b0;
    retire(mk(32'h2000, 32'h1234_5678, SIZE_BYTE), 1'b1);
    cycle();
    sq_head = mk(32'h3000, 32'hDEAD_BEEF, SIZE_HALF);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_valid",   dc_req_valid, 1'b1);
      check("bp_stall",   dcache_store_stall, 1'b1);
      check("bp_retire",  sq_retire, 1'b0);
      check("bp_payload", dc_req, mk(32'h2000, 32'h1234_5678, SIZE_BYTE));
      cycle();
    end
    rob2sq_retire_en = 1'b0;
    sq_head_valid    = 1'b0;
    dc_req_ready     = 1'b1;
    cycle();
    check("bp_cnt",       outstanding_cnt, 1);
    check("bp_valid_off", dc_req_valid, 1'b0);
    dc_resp_valid = 1'b1;
    cycle();
    dc_resp_valid = 1'b0;
    check("bp_cnt_done", outstanding_cnt, 0);

    // Saturation at two outstanding writes
    retire(mk(32'h4000, 32'h0000_0001, SIZE_WORD), 1'b1);
    cycle();
    rob2sq_retire_en = 1'b0;
    cycle();
    retire(mk(32'h4004, 32'h0000_0002, SIZE_HALF), 1'b1);
    cycle();
    rob2sq_retire_en = 1'b0;
    cycle();
    check("sat_cnt",   outstanding_cnt, 2);
    check("sat_stall", dcache_store_stall, 1'b1);
    retire(mk(32'h4008, 32'h0000_0003, SIZE_DOUBLE), 1'b0);
    cycle();
    #1;
    check("sat_blocked", sq_retire, 1'b0);
    dc_resp_valid = 1'b1;
    #1;
    check("sat_resp_cycle", sq_retire, 1'b0);
    cycle();
    dc_resp_valid = 1'b0;
    check("sat_cnt_after_resp", outstanding_cnt, 1);
    check("sat_stall_release",  dcache_store_stall, 1'b0);
    retire(mk(32'h4008, 32'h0000_0003, SIZE_DOUBLE), 1'b1);
    cycle();
    rob2sq_retire_en = 1'b0;
    sq_head_valid    = 1'b0;
    #1;
    check("sat_third_valid", dc_req_valid, 1'b1);

    // Issue and response in the same cycle with one outstanding
    dc_resp_valid = 1'b1;
    cycle();
    dc_resp_valid = 1'b0;
    check("simul_cnt", outstanding_cnt, 1);
    check("simul_err", err, 1'b0);
    dc_resp_valid = 1'b1;
    cycle();
    dc_resp_valid = 1'b0;
    check("simul_drain_cnt", outstanding_cnt, 0);
    check("simul_drained",   drained, 1'b1);

    // Response with nothing outstanding
    dc_resp_valid = 1'b1;
    cycle();
    dc_resp_valid = 1'b0;
    check("resp_err_cnt", outstanding_cnt, 0);
    check("resp_err_flag", err, 1'b1);

    // Reset while holding a request with one write outstanding
    retire(mk(32'h5000, 32'h5555_5555, SIZE_WORD), 1'b1);
    cycle();
    rob2sq_retire_en = 1'b0;
    cycle();
    dc_req_ready = 1'b0;
    retire(mk(32'h6000, 32'h6666_6666, SIZE_BYTE), 1'b1);
    cycle();
    rob2sq_retire_en = 1'b0;
    sq_head_valid    = 1'b0;
    #1;
    check("mid_valid", dc_req_valid, 1'b1);
    check("mid_cnt",   outstanding_cnt, 1);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid",   dc_req_valid, 1'b0);
    check("mid_rst_cnt",     outstanding_cnt, 0);
    check("mid_rst_stall",   dcache_store_stall, 1'b0);
    check("mid_rst_err",     err, 1'b0);
    check("mid_rst_drained", drained, 1'b1);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Retire with an empty SQ head
    dc_req_ready     = 1'b1;
    rob2sq_retire_en = 1'b1;
    sq_head_valid    = 1'b0;
    sq_head          = mk(32'h7000, 32'h7777_7777, SIZE_WORD);
    #1;
    check("hv0_retire", sq_retire, 1'b0);
    cycle();
    rob2sq_retire_en = 1'b0;
    #1;
    check("hv0_valid",   dc_req_valid, 1'b0);
    check("hv0_err",     err, 1'b1);
    check("hv0_drained", drained, 1'b1);
    check("hv0_payload", dc_req, 0);
    cycle();
    check("err_sticky", err, 1'b1);
    check("sb_empty_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
